// File: rtl/cache_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | cache_pkg                                                            |
// | Shared types and address-field helpers for assoc_cache.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package cache_pkg;

  // Controller states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    REPLAY = 2'd2
  } state_t;

  // Tags are stored zero-extended to this width; the unused upper bits stay constant
  localparam int TAG_MAX_W = 32;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
  } meta_t;

  function automatic int bsel_w(input int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int off_w(input int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int addr_w, input int data_w, input int sets,
                               input int line_words);
    return addr_w - bsel_w(data_w) - off_w(line_words) - idx_w(sets);
  endfunction

  // A direct-mapped cache still needs a one-bit way number to keep vectors legal
  function automatic int way_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/way_victim_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | way_victim_sel                                                       |
// | Victim way choice: lowest invalid way, else per-set round-robin.     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module way_victim_sel
  import cache_pkg::*;
#(
  parameter int SETS = 64,
  parameter int WAYS = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [idx_w(SETS)-1:0]   set_idx,
  input  logic [WAYS-1:0]          set_valid,
  input  logic                     advance,
  output logic [way_w(WAYS)-1:0]   victim
);
  localparam int WAY_W = way_w(WAYS);

  logic [WAY_W-1:0] rr [SETS];
  logic             all_valid;

  // Scan from the top so the lowest-numbered invalid way wins
  always_comb begin
    victim    = rr[set_idx];
    all_valid = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!set_valid[w]) begin
        victim    = WAY_W'(w);
        all_valid = 1'b0;
      end
    end
  end

  // Pointer only moves when it actually picked the victim
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else if (advance && all_valid) begin
      rr[set_idx] <= (rr[set_idx] == WAY_W'(WAYS - 1)) ? '0 : rr[set_idx] + WAY_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/assoc_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | assoc_cache                                                          |
// | Set-associative write-through, write-allocate cache with line fill.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module assoc_cache
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdata_valid,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int BSEL_W = bsel_w(DATA_W);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(ADDR_W, DATA_W, SETS, LINE_WORDS);
  localparam int WAY_W  = way_w(WAYS);
  localparam int DIDX_W = $clog2(WAYS * SETS * LINE_WORDS);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'((1 << BSEL_W) - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'((1 << (BSEL_W + OFF_W)) - 1);
  localparam logic [OFF_W:0]    ISSUE_END = (OFF_W + 1)'(LINE_WORDS);

  state_t            state, state_nx;
  meta_t             meta     [WAYS][SETS];
  logic [DATA_W-1:0] data_mem [WAYS*SETS*LINE_WORDS];

  logic              lat_wr;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [WAY_W-1:0]  vic;
  logic [OFF_W:0]    issue_cnt;
  logic [OFF_W-1:0]  ret_cnt;

  logic [ADDR_W-1:0] look_addr;
  logic [OFF_W-1:0]  look_off;
  logic [IDX_W-1:0]  look_idx, lat_idx;
  logic [TAG_W-1:0]  look_tag, lat_tag;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, victim;
  logic [WAYS-1:0]   set_valid;
  logic              accept, hit_acc, miss_acc, fill_we, fill_last, replay, do_access, acc_wr;
  logic [DATA_W-1:0] acc_wdata, rd_word;

  function automatic logic [DIDX_W-1:0] didx(input logic [WAY_W-1:0] w,
                                             input logic [IDX_W-1:0] s,
                                             input logic [OFF_W-1:0] o);
    return DIDX_W'(w) * DIDX_W'(SETS * LINE_WORDS) + DIDX_W'(s) * DIDX_W'(LINE_WORDS)
           + DIDX_W'(o);
  endfunction

  // REPLAY looks up the latched request, IDLE the live one
  assign look_addr = (state == REPLAY) ? lat_addr : req_addr;
  assign look_off  = look_addr[BSEL_W +: OFF_W];
  assign look_idx  = look_addr[BSEL_W + OFF_W +: IDX_W];
  assign look_tag  = look_addr[ADDR_W-1 -: TAG_W];
  assign lat_idx   = lat_addr[BSEL_W + OFF_W +: IDX_W];
  assign lat_tag   = lat_addr[ADDR_W-1 -: TAG_W];
  assign req_ready = (state == IDLE);
  assign rd_word   = data_mem[didx(hit_way, look_idx, look_off)];

  // Tag compare across all ways of the indexed set
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    set_valid = '0;
    for (int w = 0; w < WAYS; w++) begin
      set_valid[w] = meta[w][look_idx].valid;
      if (meta[w][look_idx].valid && (meta[w][look_idx].tag == TAG_MAX_W'(look_tag))) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  way_victim_sel #(
    .SETS (SETS),
    .WAYS (WAYS)
  ) u_victim (
    .clk       (clk),
    .rst_n     (rst_n),
    .set_idx   (look_idx),
    .set_valid (set_valid),
    .advance   (miss_acc),
    .victim    (victim)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and per-cycle strobes
  always_comb begin
    state_nx  = state;
    replay    = (state == REPLAY);
    accept    = (state == IDLE) && req_valid;
    hit_acc   = accept && hit;
    miss_acc  = accept && !hit;
    fill_we   = (state == FILL) && mem_rdata_valid;
    fill_last = fill_we && (ret_cnt == OFF_W'(LINE_WORDS - 1));
    do_access = hit_acc || replay;
    acc_wr    = replay ? lat_wr : req_wr;
    acc_wdata = replay ? lat_wdata : req_wdata;
    case (state)
      IDLE:    if (miss_acc) state_nx = FILL;
      FILL:    if (fill_last) state_nx = REPLAY;
      REPLAY:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Data array: fill returns and write hits (never both in one cycle)
  always_ff @(posedge clk) begin
    if (fill_we)
      data_mem[didx(vic, lat_idx, ret_cnt)] <= mem_rdata;
    else if (do_access && acc_wr)
      data_mem[didx(hit_way, look_idx, look_off)] <= acc_wdata;
  end

  // Metadata, request latch, fill sequencing, outputs and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) meta[w][s] <= '0;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      vic        <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_cnt    <= '0;
      miss_cnt   <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;

      if (do_access) begin
        resp_valid <= 1'b1;
        if (acc_wr) begin
          mem_wr    <= 1'b1;
          mem_addr  <= look_addr & WORD_MASK;
          mem_wdata <= acc_wdata;
        end else begin
          resp_rdata <= rd_word;
        end
      end

      if (hit_acc && (hit_cnt != {CNT_W{1'b1}})) hit_cnt <= hit_cnt + CNT_W'(1);

      if (miss_acc) begin
        if (miss_cnt != {CNT_W{1'b1}}) miss_cnt <= miss_cnt + CNT_W'(1);
        lat_wr                     <= req_wr;
        lat_addr                   <= req_addr;
        lat_wdata                  <= req_wdata;
        vic                        <= victim;
        meta[victim][look_idx].valid <= 1'b0;
        mem_rd                     <= 1'b1;
        mem_addr                   <= req_addr & LINE_MASK;
        issue_cnt                  <= (OFF_W + 1)'(1);
        ret_cnt                    <= '0;
      end

      if ((state == FILL) && (issue_cnt != ISSUE_END)) begin
        mem_rd    <= 1'b1;
        mem_addr  <= (lat_addr & LINE_MASK) | (ADDR_W'(issue_cnt[OFF_W-1:0]) << BSEL_W);
        issue_cnt <= issue_cnt + (OFF_W + 1)'(1);
      end

      if (fill_we) begin
        ret_cnt <= ret_cnt + OFF_W'(1);
        if (fill_last) meta[vic][lat_idx] <= {1'b1, TAG_MAX_W'(lat_tag)};
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_assoc_cache                                                       |
// | Scoreboard bench for assoc_cache with a pipelined memory model.      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_assoc_cache;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [15:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, resp_valid, mem_rd, mem_wr;
  logic [15:0] resp_rdata, mem_addr, mem_wdata;
  logic [15:0] mem_rdata = '0;
  logic        mem_rdata_valid = 1'b0;
  logic [15:0] hit_cnt, miss_cnt;

  // Narrow-counter instance sharing the same stimulus
  logic        ready4, resp_valid4, mem_rd4, mem_wr4;
  logic [15:0] resp_rdata4, mem_addr4, mem_wdata4;
  logic [3:0]  hit4, miss4;

  always #5 clk = ~clk;

  assoc_cache dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  assoc_cache #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready4), .resp_valid(resp_valid4),
    .resp_rdata(resp_rdata4), .mem_addr(mem_addr4), .mem_rd(mem_rd4), .mem_wr(mem_wr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid),
    .hit_cnt(hit4), .miss_cnt(miss4)
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
  } wr_t;

  int          total = 0, bad = 0;
  int          resp_cnt = 0, exp_hits = 0, exp_misses = 0;
  logic [15:0] exp_q [$];
  logic [15:0] rd_q  [$];
  wr_t         wr_q  [$];
  wr_t         mon_w;
  logic [15:0] mem_store [logic [15:0]];
  logic        pv0 = 1'b0, pv1 = 1'b0;
  logic [15:0] pa0 = '0, pa1 = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] memval(input logic [15:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return a;
  endfunction

  // Output monitor and memory with one cycle of read latency
  always @(negedge clk) begin
    if (rst_n) begin
      check("rd_wr_excl", 32'(mem_rd & mem_wr), 0);
      if (resp_valid) begin
        check("resp_expected", 32'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) check("resp_rdata", 32'(resp_rdata), 32'(exp_q.pop_front()));
        resp_cnt++;
      end
      if (mem_rd) begin
        check("mem_rd_expected", 32'(rd_q.size() != 0), 1);
        if (rd_q.size() != 0) check("mem_rd_addr", 32'(mem_addr), 32'(rd_q.pop_front()));
      end
      if (mem_wr) begin
        check("mem_wr_expected", 32'(wr_q.size() != 0), 1);
        if (wr_q.size() != 0) begin
          mon_w = wr_q.pop_front();
          check("mem_wr_addr", 32'(mem_addr), 32'(mon_w.addr));
          check("mem_wr_data", 32'(mem_wdata), 32'(mon_w.data));
        end
        mem_store[mem_addr] = mem_wdata;
      end
    end
    pv1 = pv0;
    pa1 = pa0;
    pv0 = mem_rd;
    pa0 = mem_addr;
    mem_rdata_valid = pv1;
    mem_rdata       = pv1 ? memval(pa1) : 16'h0;
  end

  // Junk request held while the cache is busy; it must be ignored
  task automatic junk();
    req_valid = !req_ready;
    req_wr    = 1'b1;
    req_addr  = 16'hFFFE;
    req_wdata = 16'hDEAD;
  endtask

  task automatic access(input bit wr, input logic [15:0] a, input logic [15:0] wd,
                        input bit hit, input logic [15:0] rd);
    int  start;
    int  cyc;
    wr_t w;
    @(negedge clk); #1;
    check("req_ready", 32'(req_ready), 1);
    req_valid = 1'b1; req_wr = wr; req_addr = a; req_wdata = wd;
    exp_q.push_back(wr ? 16'h0 : rd);
    if (!hit) for (int k = 0; k < 8; k++) rd_q.push_back((a & 16'hFFF0) + 16'(2 * k));
    if (wr) begin
      w.addr = a & 16'hFFFE;
      w.data = wd;
      wr_q.push_back(w);
    end
    if (hit) exp_hits++; else exp_misses++;
    start = resp_cnt;
    @(posedge clk); #1;
    junk();
    cyc = 0;
    while (resp_cnt == start && cyc < 100) begin
      @(negedge clk); #1;
      cyc++;
      junk();
    end
    check("resp_seen", 32'(resp_cnt != start), 1);
    check("latency", cyc, hit ? 1 : 11);
    check("hit_cnt", 32'(hit_cnt), exp_hits);
    check("miss_cnt", 32'(miss_cnt), exp_misses);
  endtask

  initial begin
    int n;
    int cyc;
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 32'(req_ready), 1);
    check("rst_outputs", {resp_valid, mem_rd, mem_wr, resp_rdata, mem_addr}, 0);
    check("rst_counters", {hit_cnt, miss_cnt}, 0);
    @(negedge clk); rst_n = 1'b1;

    // cold read, then hits in the same line
    access(0, 16'h1230, 0, 0, 16'h1230);
    access(0, 16'h1236, 0, 1, 16'h1236);
    access(0, 16'h1237, 0, 1, 16'h1236);
    access(1, 16'h1234, 16'h5555, 1, 0);
    access(0, 16'h1234, 0, 1, 16'h5555);

    // three tags in set 0 with two ways
    access(0, 16'h0400, 0, 0, 16'h0400);
    access(0, 16'h0800, 0, 0, 16'h0800);
    access(0, 16'h0C00, 0, 0, 16'h0C00);
    access(0, 16'h0800, 0, 1, 16'h0800);
    access(0, 16'h0400, 0, 0, 16'h0400);
    access(0, 16'h0C02, 0, 1, 16'h0C02);

    // write miss allocates, then writes through
    access(1, 16'h2002, 16'hBEEF, 0, 0);
    access(0, 16'h2002, 0, 1, 16'hBEEF);
    access(0, 16'h2004, 0, 1, 16'h2004);
    access(0, 16'h0400, 0, 1, 16'h0400);

    // reset in the middle of a fill
    @(negedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h3000;
    for (int k = 0; k < 8; k++) rd_q.push_back(16'h3000 + 16'(2 * k));
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    cyc = 0;
    while (n < 3 && cyc < 100) begin
      @(negedge clk); #1;
      if (mem_rdata_valid) n++;
      cyc++;
    end
    check("fill_returns_seen", n, 3);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("fill_rst_ready", 32'(req_ready), 1);
    check("fill_rst_outputs", {resp_valid, mem_rd, mem_wr}, 0);
    check("fill_rst_counters", {hit_cnt, miss_cnt}, 0);
    rd_q.delete();
    exp_hits = 0;
    exp_misses = 0;
    @(negedge clk); rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #1;
    check("late_return_idle", 32'(req_ready), 1);
    access(0, 16'h3000, 0, 0, 16'h3000);
    access(0, 16'h1230, 0, 0, 16'h1230);

    // saturation of the narrow counter
    for (int i = 0; i < 20; i++) begin
      access(0, 16'h3000 + 16'(2 * (i % 8)), 0, 1, 16'h3000 + 16'(2 * (i % 8)));
      check("hit_cnt4", 32'(hit4), (exp_hits > 15) ? 15 : exp_hits);
    end
    check("miss_cnt4", 32'(miss4), exp_misses);

    repeat (4) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    check("wr_q_drained", wr_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=running want=finished");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/assoc_cache.md
ASSOC_CACHE -- requirements
Module: assoc_cache

Interface
REQ-001 Parameter ADDR_W, 16, byte address width.
REQ-002 Parameter DATA_W, 16, word width; one word = DATA_W/8 bytes.
REQ-003 Parameter SETS, 64, number of sets; power of 2, at least 2.
REQ-004 Parameter WAYS, 2, associativity; power of 2, at least 1.
REQ-005 Parameter LINE_WORDS, 8, words per line; power of 2, at least 2.
REQ-006 Parameter CNT_W, 16, width of the performance counters.
REQ-007 clk  input  1  single clock; all state updates on the rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 req_valid  input  1  access request; accepted when req_valid && req_ready.
REQ-010 req_wr  input  1  1 = write, 0 = read.
REQ-011 req_addr  input  ADDR_W  byte address; the byte-select bits below word granularity are ignored.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 req_ready  output  1  high only in IDLE.
REQ-014 resp_valid  output  1  one-cycle pulse: access completed.
REQ-015 resp_rdata  output  DATA_W  read data, valid with resp_valid on reads; 0 otherwise.
REQ-016 mem_addr  output  ADDR_W  memory word address, byte-select bits 0.
REQ-017 mem_rd  output  1  one-cycle memory read issue.
REQ-018 mem_wr  output  1  one-cycle memory write issue.
REQ-019 mem_wdata  output  DATA_W  memory write data.
REQ-020 mem_rdata  input  DATA_W  memory read data.
REQ-021 mem_rdata_valid  input  1  mem_rdata valid; returns are in issue order, any latency, memory is pipelined.
REQ-022 hit_cnt, miss_cnt  output  CNT_W  saturating counts of accepted hits and misses.

Function
REQ-023 Address split, from LSB upward: byte-select, word offset log2(LINE_WORDS), index log2(SETS), tag = the remaining upper bits.
REQ-024 Per way and set, the block SHALL hold a valid bit, a tag and LINE_WORDS data words.
REQ-025 Hit = any way in the indexed set is valid with a matching tag; at most one way SHALL ever match.
REQ-026 FSM states: IDLE, FILL, REPLAY; IDLE -> FILL on an accepted miss; FILL -> REPLAY when the last fill word is written; REPLAY -> IDLE after one cycle.
REQ-027 Read hit accepted in cycle N: resp_valid and resp_rdata SHALL appear in cycle N+1; the FSM stays in IDLE.
REQ-028 Write hit, write-through: the hit word SHALL be updated at edge N; mem_wr=1 with mem_addr/mem_wdata in cycle N+1; resp_valid in cycle N+1.
REQ-029 Miss (read or write), write-allocate: latch the request; victim = lowest-numbered invalid way, else the set's round-robin pointer, which then increments modulo WAYS.
REQ-030 FILL issue: mem_rd for words 0..LINE_WORDS-1 of the line, one per cycle, starting the cycle after acceptance.
REQ-031 FILL return: the k-th mem_rdata_valid SHALL write word k of the victim way; the victim's valid bit is cleared at fill start and set, with the new tag, on the last word.
REQ-032 REPLAY re-executes the latched access as a hit (REQ-027/REQ-028 timing, relative to the REPLAY cycle).
REQ-033 A miss costs LINE_WORDS issue cycles plus memory latency plus 2 cycles.
REQ-034 mem_rd and mem_wr SHALL never be high in the same cycle.
REQ-035 mem_rdata_valid outside FILL SHALL be ignored.
REQ-036 Request inputs are ignored while req_ready=0.
REQ-037 hit_cnt increments per accepted hit and miss_cnt per accepted miss; a replay SHALL NOT count as a hit; both saturate at all-ones.

Reset
REQ-038 rst_n low SHALL clear all valid bits, round-robin pointers and counters; FSM -> IDLE; all outputs 0 except req_ready=1.
REQ-039 Reset during FILL abandons the fill; a late mem_rdata_valid after reset SHALL NOT modify the cache.
REQ-040 Data arrays need not be reset.

Structure
REQ-041 Shared package cache_pkg: the FSM state enum, address-field width functions (offset/index/tag) and the metadata struct {valid, tag}.
REQ-042 One sub-module, way_victim_sel: per-set round-robin pointers plus invalid-first victim choice.

Verification
REQ-043 Defaults; read 0x1230 cold, memory word = address -> 8 mem_rd at 0x1230..0x123E, resp_rdata=0x1230 after REPLAY, miss_cnt=1.
REQ-044 Then read 0x1236 -> resp_rdata=0x1236 next cycle, no mem_rd, hit_cnt=1.
REQ-045 Same index, tags A, B, C (0x0400, 0x0800, 0x0C00) -> C evicts way 0 (A); a re-read of B hits, a re-read of A misses.
REQ-046 Write 0xBEEF to a cold 0x2002 -> fill, then a single mem_wr to 0x2002 with 0xBEEF; a subsequent read of 0x2002 hits and returns 0xBEEF.
REQ-047 rst_n pulsed low after 3 fill returns -> req_ready=1 immediately; remaining returns ignored; a re-read misses.
REQ-048 CNT_W=4, 20 hits -> hit_cnt holds at 0xF.
